// File: rtl/pulse_pkg.sv
// Shared state encoding for the pulse-shaping blocks.
package pulse_pkg;

   localparam int unsigned ST_W = 2;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_HIGH = 2'b01;
   localparam logic [1:0] ST_GAP  = 2'b10;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down counter that saturates at 1 (never wraps through zero).
module load_down_counter #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] cnt
);

   // Load has priority; decrement only while above one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt > CNT_W'(1))) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches a single-cycle trigger into a len-cycle high level followed by a forced-low gap.
module pulse_stretcher
   import pulse_pkg::*;
#(
   parameter int unsigned CNT_W      = 8,
   parameter int unsigned GAP_CYCLES = 2,
   parameter bit          RETRIG     = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic [CNT_W-1:0] len,
   output logic             z,
   output logic             busy,
   output logic             done,
   output logic             drop
);

   logic [ST_W-1:0]  state;
   logic [ST_W-1:0]  state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] load_val;
   logic             load;
   logic             dec;
   logic             done_nx;
   logic             drop_nx;
   logic             cnt_last;

   assign cnt_last = (cnt <= CNT_W'(1));

   load_down_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .dec      (dec),
      .cnt      (cnt)
   );

   // Next-state, counter control and next-output decode.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      load_val = '0;
      dec      = 1'b0;
      done_nx  = 1'b0;
      drop_nx  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trig) begin
               if (len != '0) begin
                  state_nx = ST_HIGH;
                  load     = 1'b1;
                  load_val = len;
               end else begin
                  drop_nx = 1'b1;
               end
            end
         end
         ST_HIGH: begin
            if (trig && RETRIG && (len != '0)) begin
               // Retrigger wins over expiry, even on the last high cycle.
               load     = 1'b1;
               load_val = len;
            end else begin
               drop_nx = trig;
               if (cnt_last) begin
                  done_nx = 1'b1;
                  if (GAP_CYCLES == 0) begin
                     state_nx = ST_IDLE;
                  end else begin
                     state_nx = ST_GAP;
                     load     = 1'b1;
                     load_val = CNT_W'(GAP_CYCLES);
                  end
               end else begin
                  dec = 1'b1;
               end
            end
         end
         ST_GAP: begin
            drop_nx = trig;
            if (cnt_last) begin
               state_nx = ST_IDLE;
            end else begin
               dec = 1'b1;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; outputs decode the next state so they align with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         z     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         drop  <= 1'b0;
      end else begin
         state <= state_nx;
         z     <= (state_nx == ST_HIGH);
         busy  <= (state_nx != ST_IDLE);
         done  <= done_nx;
         drop  <= drop_nx;
      end
   end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Randomized + directed bench for pulse_stretcher against a remaining-time reference model.
module tb_pulse_stretcher;

   localparam int unsigned NI = 3;

   logic       clk;
   logic       rst;
   logic       trig;
   logic [7:0] len;
   logic       z    [NI];
   logic       busy [NI];
   logic       done [NI];
   logic       drop [NI];

   int errors;
   int checks;

   // Reference state: cycles of high and gap still to come, plus expected outputs.
   int hi_left  [NI];
   int gap_left [NI];
   bit e_z      [NI];
   bit e_busy   [NI];
   bit e_done   [NI];
   bit e_drop   [NI];

   // Instance 0: defaults. Instance 1: retrigger enabled. Instance 2: no gap.
   pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(2), .RETRIG(1'b0)) u_d0 (
      .clk(clk), .rst(rst), .trig(trig), .len(len),
      .z(z[0]), .busy(busy[0]), .done(done[0]), .drop(drop[0]));
   pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(2), .RETRIG(1'b1)) u_d1 (
      .clk(clk), .rst(rst), .trig(trig), .len(len),
      .z(z[1]), .busy(busy[1]), .done(done[1]), .drop(drop[1]));
   pulse_stretcher #(.CNT_W(8), .GAP_CYCLES(0), .RETRIG(1'b0)) u_d2 (
      .clk(clk), .rst(rst), .trig(trig), .len(len),
      .z(z[2]), .busy(busy[2]), .done(done[2]), .drop(drop[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int gap_of(input int i);
      return (i == 2) ? 0 : 2;
   endfunction

   function automatic bit retrig_of(input int i);
      return (i == 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         hi_left[i] = 0; gap_left[i] = 0;
         e_z[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_drop[i] = 0;
      end
   endtask

   // One rising edge of the reference: what happens to each pulse given this trig/len.
   task automatic model_step(input bit t, input int l);
      for (int i = 0; i < NI; i++) begin
         e_done[i] = 0;
         e_drop[i] = 0;
         if (hi_left[i] > 0) begin
            if (t && retrig_of(i) && l != 0) begin
               hi_left[i] = l;
            end else begin
               if (t) e_drop[i] = 1;
               hi_left[i] = hi_left[i] - 1;
               if (hi_left[i] == 0) begin
                  e_done[i] = 1;
                  gap_left[i] = gap_of(i);
               end
            end
         end else if (gap_left[i] > 0) begin
            if (t) e_drop[i] = 1;
            gap_left[i] = gap_left[i] - 1;
         end else if (t) begin
            if (l != 0) hi_left[i] = l;
            else e_drop[i] = 1;
         end
         e_z[i]    = (hi_left[i] > 0);
         e_busy[i] = (hi_left[i] > 0) || (gap_left[i] > 0);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("%s_z%0d", tag, i),    32'(z[i]),    32'(e_z[i]));
         chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'(e_busy[i]));
         chk($sformatf("%s_done%0d", tag, i), 32'(done[i]), 32'(e_done[i]));
         chk($sformatf("%s_drop%0d", tag, i), 32'(drop[i]), 32'(e_drop[i]));
      end
   endtask

   task automatic tick(input string tag, input bit t, input int l);
      @(negedge clk);
      trig = t;
      len  = 8'(l);
      @(posedge clk);
      model_step(t, l);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick("idle", 1'b0, 0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear without a clock.
   task automatic apply_reset(input int hold);
      @(negedge clk);
      trig = 1'b0;
      len  = '0;
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("rst_async");
      repeat (hold) @(posedge clk);
      #1;
      check_all("rst_hold");
      @(negedge clk);
      rst = 1'b0;
   endtask

   int n_z, n_busy, n_done;

   initial begin
      errors = 0;
      checks = 0;
      rst  = 1'b1;
      trig = 1'b0;
      len  = '0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;

      // Basic pulse: len=5 on defaults.
      n_z = 0; n_busy = 0; n_done = 0;
      tick("basic", 1'b1, 5);
      n_z += int'(z[0]); n_busy += int'(busy[0]); n_done += int'(done[0]);
      for (int k = 0; k < 11; k++) begin
         tick("basic", 1'b0, 0);
         n_z += int'(z[0]); n_busy += int'(busy[0]); n_done += int'(done[0]);
      end
      chk("basic_zlen",  32'(n_z),    32'd5);
      chk("basic_busy",  32'(n_busy), 32'd7);
      chk("basic_ndone", 32'(n_done), 32'd1);

      // Drops during pulse and gap.
      tick("drop", 1'b1, 4);
      tick("drop", 1'b0, 0);
      tick("drop", 1'b1, 4);
      tick("drop", 1'b0, 0);
      tick("drop", 1'b0, 0);
      tick("drop", 1'b1, 4);
      idle(10);

      // Retrigger two edges into a len=3 pulse.
      n_z = 0; n_done = 0;
      tick("retrig", 1'b1, 3);
      n_z += int'(z[1]); n_done += int'(done[1]);
      tick("retrig", 1'b0, 0);
      n_z += int'(z[1]); n_done += int'(done[1]);
      tick("retrig", 1'b1, 3);
      n_z += int'(z[1]); n_done += int'(done[1]);
      for (int k = 0; k < 10; k++) begin
         tick("retrig", 1'b0, 0);
         n_z += int'(z[1]); n_done += int'(done[1]);
      end
      chk("retrig_zlen",  32'(n_z),    32'd5);
      chk("retrig_ndone", 32'(n_done), 32'd1);

      // Retrigger on the last high cycle of a len=2 pulse.
      tick("retrig_last", 1'b1, 2);
      tick("retrig_last", 1'b1, 2);
      idle(10);

      // Zero length in idle.
      tick("zero", 1'b1, 0);
      idle(3);

      // Reset in the middle of a long pulse, then a len=1 pulse right after release.
      tick("long", 1'b1, 200);
      idle(10);
      apply_reset(2);
      tick("post_rst", 1'b1, 1);
      idle(6);

      // Back-to-back len=1 every two cycles.
      for (int k = 0; k < 6; k++) begin
         tick("b2b", 1'b1, 1);
         tick("b2b", 1'b0, 0);
      end
      idle(6);

      // Reset in the middle of a gap.
      tick("gap_rst", 1'b1, 1);
      tick("gap_rst", 1'b0, 0);
      apply_reset(1);

      // Random traffic.
      for (int k = 0; k < 600; k++) begin
         bit t;
         int l;
         t = ($urandom_range(0, 2) == 0);
         l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 6));
         tick("rand", t, l);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
